get_buffer: RTL

//   Receive-side word buffer directly downstream of the get-stream enable stage.

---
 rtl/get_buffer.sv | 107 ++++++++++
 1 files changed

// File: rtl/get_buffer.sv
// Receive-side word buffer: captures get-stream words into a DEPTH-entry FIFO and
// presents them to the core over a registered valid/ready interface.
module get_buffer #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CW    = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          get_v,
  input  logic [DW-1:0] get_data,
  input  logic          exec_ready,
  output logic          exec_valid,
  output logic [DW-1:0] exec_data,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          overflow,
  output logic [CW-1:0] recv_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(DEPTH - 2);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_exec_valid;
  logic [DW-1:0] r_exec_data;
  logic          r_overflow;
  logic [CW-1:0] r_recv_cnt;

  logic          w_wr;
  logic          w_rd;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [AW:0]   w_count_nxt;
  logic [DW-1:0] w_head_nxt;

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_rd = run & r_exec_valid & exec_ready;
  assign w_wr = run & get_v & ((r_count != FULL_CNT) | w_rd);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_rd) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    unique case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
    // The incoming word becomes the head only when it lands in the slot the
    // read pointer will point at, i.e. the FIFO is (or is becoming) empty.
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = get_data;
  end

  // NOTE: storage array has no reset; its contents are only observable through
  // exec_data once count says the slot holds a valid word.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= get_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_exec_valid <= 1'b0;
      r_exec_data  <= '0;
      r_overflow   <= 1'b0;
      r_recv_cnt   <= '0;
    end else if (!run) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_exec_valid <= 1'b0;
      r_exec_data  <= '0;
      r_overflow   <= 1'b0;
      r_recv_cnt   <= '0;
    end else begin
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_exec_valid <= (w_count_nxt != '0);
      r_exec_data  <= w_head_nxt;
      if (w_wr) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_recv_cnt <= r_recv_cnt + CW'(1);
      end
      if (get_v && !w_wr) r_overflow <= 1'b1;
    end
  end

  assign exec_valid  = r_exec_valid;
  assign exec_data   = r_exec_data;
  assign count       = r_count;
  assign almost_full = (r_count >= AF_CNT);
  assign overflow    = r_overflow;
  assign recv_cnt    = r_recv_cnt;

endmodule
